// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: decode-side request and hazard/forwarding response bundle
interface hazard_scoreboard_if #(
  parameter int REG_AW = 5,
  parameter int LAT_W  = 2,
  parameter int SEL_W  = 2,
  parameter int CNT_W  = 32
);
  logic              id_valid;
  logic              id_use_rs;
  logic              id_use_rt;
  logic              id_is_store;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_reg_write;
  logic [REG_AW-1:0] id_dest;
  logic [LAT_W-1:0]  id_lat;
  logic              flush;
  logic              stall;
  logic [SEL_W-1:0]  fwd_sel_a;
  logic [SEL_W-1:0]  fwd_sel_b;
  logic              late_fwd_b;
  logic [CNT_W-1:0]  stall_count;
  modport master (
    output id_valid, id_use_rs, id_use_rt, id_is_store, id_rs, id_rt,
           id_reg_write, id_dest, id_lat, flush,
    input  stall, fwd_sel_a, fwd_sel_b, late_fwd_b, stall_count
  );
  modport slave (
    input  id_valid, id_use_rs, id_use_rt, id_is_store, id_rs, id_rt,
           id_reg_write, id_dest, id_lat, flush,
    output stall, fwd_sel_a, fwd_sel_b, late_fwd_b, stall_count
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: shift-register scoreboard of in-flight writers driving
// decode stall, operand forward selects, late store-data forwarding and a stall counter
module hazard_scoreboard #(
  parameter int REG_AW = 5,
  parameter int STAGES = 3,
  parameter int LAT_W  = 2,
  parameter int SEL_W  = 2,
  parameter int CNT_W  = 32
) (
  input logic clk,
  input logic rst,
  hazard_scoreboard_if.slave bus
);
  localparam logic [LAT_W-1:0] LAT_MAX = LAT_W'(STAGES - 1);
  logic [STAGES-1:0] r_valid;
  logic [REG_AW-1:0] r_dest [STAGES];
  logic [LAT_W-1:0]  r_lat  [STAGES];
  logic [CNT_W-1:0]  r_cnt;
  logic              w_hit_a, w_hit_b;
  logic [SEL_W-1:0]  w_pos_a, w_pos_b;
  logic [LAT_W-1:0]  w_lat_a, w_lat_b;
  logic              w_use_a, w_use_b, w_haz_a, w_haz_b, w_late, w_stall, w_ins;
  logic [LAT_W-1:0]  w_lat_in;
  // Scan oldest to youngest so the lowest matching position wins.
  always_comb begin
    w_hit_a = 1'b0;
    w_pos_a = '0;
    w_lat_a = '0;
    w_hit_b = 1'b0;
    w_pos_b = '0;
    w_lat_b = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      if (r_valid[i] && r_dest[i] == bus.id_rs) begin
        w_hit_a = 1'b1;
        w_pos_a = SEL_W'(i + 1);
        w_lat_a = r_lat[i];
      end
      if (r_valid[i] && r_dest[i] == bus.id_rt) begin
        w_hit_b = 1'b1;
        w_pos_b = SEL_W'(i + 1);
        w_lat_b = r_lat[i];
      end
    end
  end
  assign w_use_a = bus.id_use_rs && bus.id_rs != '0;
  assign w_use_b = bus.id_use_rt && bus.id_rt != '0;
  // A load one cycle ahead of a store can still supply its data in M.
  assign w_late  = w_use_b && bus.id_is_store && w_hit_b && w_pos_b == SEL_W'(1)
                   && w_lat_b == LAT_W'(1);
  assign w_haz_a = w_use_a && w_hit_a && w_lat_a != '0;
  assign w_haz_b = w_use_b && w_hit_b && w_lat_b != '0 && !w_late;
  assign w_stall = bus.id_valid && !bus.flush && (w_haz_a || w_haz_b);
  assign w_ins   = bus.id_valid && bus.id_reg_write && bus.id_dest != '0 && !w_stall && !bus.flush;
  assign w_lat_in = bus.id_lat > LAT_MAX ? LAT_MAX : bus.id_lat;
  assign bus.stall       = w_stall;
  assign bus.fwd_sel_a   = (w_use_a && w_hit_a && w_lat_a == '0) ? w_pos_a : '0;
  assign bus.fwd_sel_b   = (w_use_b && w_hit_b && w_lat_b == '0) ? w_pos_b : '0;
  assign bus.late_fwd_b  = w_late;
  assign bus.stall_count = r_cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      r_cnt   <= '0;
      for (int i = 0; i < STAGES; i++) begin
        r_dest[i] <= '0;
        r_lat[i]  <= '0;
      end
    end else begin
      r_valid[0] <= w_ins;
      r_dest[0]  <= bus.id_dest;
      r_lat[0]   <= w_lat_in;
      for (int i = 1; i < STAGES; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_dest[i]  <= r_dest[i-1];
        r_lat[i]   <= r_lat[i-1] == '0 ? '0 : r_lat[i-1] - LAT_W'(1);
      end
      if (w_stall && r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed scenarios; expected responses queued at drive time
module tb_hazard_scoreboard;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  hazard_scoreboard_if bus ();
  hazard_scoreboard dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct packed {
    logic       st;
    logic [1:0] sa;
    logic [1:0] sb;
    logic       lf;
  } exp_t;
  exp_t q[$];
  int errors = 0;
  int checks = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic op(input string tag, input logic v,
                    input logic ur, input logic [4:0] rs,
                    input logic ut, input logic [4:0] rt, input logic s,
                    input logic w, input logic [4:0] d, input logic [1:0] l, input logic f,
                    input logic e_st, input logic [1:0] e_sa, input logic [1:0] e_sb,
                    input logic e_lf);
    exp_t e;
    @(negedge clk);
    bus.id_valid = v;
    bus.id_use_rs = ur;
    bus.id_rs = rs;
    bus.id_use_rt = ut;
    bus.id_rt = rt;
    bus.id_is_store = s;
    bus.id_reg_write = w;
    bus.id_dest = d;
    bus.id_lat = l;
    bus.flush = f;
    q.push_back('{e_st, e_sa, e_sb, e_lf});
    #1;
    e = q.pop_front();
    chk({tag, ".stall"}, 32'(bus.stall), 32'(e.st));
    chk({tag, ".sel_a"}, 32'(bus.fwd_sel_a), 32'(e.sa));
    chk({tag, ".sel_b"}, 32'(bus.fwd_sel_b), 32'(e.sb));
    chk({tag, ".late"}, 32'(bus.late_fwd_b), 32'(e.lf));
  endtask
  initial begin
    rst = 1'b1;
    bus.id_valid = 0; bus.id_use_rs = 0; bus.id_use_rt = 0; bus.id_is_store = 0;
    bus.id_rs = 0; bus.id_rt = 0; bus.id_reg_write = 0; bus.id_dest = 0;
    bus.id_lat = 0; bus.flush = 0;
    op("rst", 1, 1, 5'd3, 1, 5'd4, 0, 0, 5'd0, 2'd0, 0, 0, 2'd0, 2'd0, 0);
    chk("rst.count", bus.stall_count, 0);
    rst = 1'b0;
    // back-to-back ALU
    op("alu_add",  1, 0, 5'd0, 0, 5'd0, 0, 1, 5'd3, 2'd0, 0, 0, 2'd0, 2'd0, 0);
    op("alu_p0",   1, 1, 5'd3, 0, 5'd0, 0, 0, 5'd0, 2'd0, 0, 0, 2'd1, 2'd0, 0);
    op("alu_p1",   1, 0, 5'd0, 1, 5'd3, 0, 0, 5'd0, 2'd0, 0, 0, 2'd0, 2'd2, 0);
    op("alu_p2",   1, 1, 5'd3, 0, 5'd0, 0, 0, 5'd0, 2'd0, 0, 0, 2'd3, 2'd0, 0);
    op("alu_ret",  1, 1, 5'd3, 1, 5'd3, 0, 0, 5'd0, 2'd0, 0, 0, 2'd0, 2'd0, 0);
    // load-use
    op("lu_lw",    1, 0, 5'd0, 0, 5'd0, 0, 1, 5'd5, 2'd1, 0, 0, 2'd0, 2'd0, 0);
    op("lu_stall", 1, 0, 5'd0, 1, 5'd5, 0, 1, 5'd6, 2'd0, 0, 1, 2'd0, 2'd0, 0);
    op("lu_fwd",   1, 0, 5'd0, 1, 5'd5, 0, 1, 5'd6, 2'd0, 0, 0, 2'd0, 2'd2, 0);
    chk("lu.count", bus.stall_count, 1);
    // load-store
    op("ls_lw",    1, 0, 5'd0, 0, 5'd0, 0, 1, 5'd5, 2'd1, 0, 0, 2'd0, 2'd0, 0);
    op("ls_sw",    1, 1, 5'd6, 1, 5'd5, 1, 0, 5'd0, 2'd0, 0, 0, 2'd2, 2'd0, 1);
    // multi-cycle; id_lat=3 clamps to 2
    op("mc_wr",    1, 0, 5'd0, 0, 5'd0, 0, 1, 5'd9, 2'd3, 0, 0, 2'd0, 2'd0, 0);
    op("mc_st1",   1, 1, 5'd9, 0, 5'd0, 0, 0, 5'd0, 2'd0, 0, 1, 2'd0, 2'd0, 0);
    op("mc_st2",   1, 1, 5'd9, 0, 5'd0, 0, 0, 5'd0, 2'd0, 0, 1, 2'd0, 2'd0, 0);
    op("mc_fwd",   1, 1, 5'd9, 0, 5'd0, 0, 0, 5'd0, 2'd0, 0, 0, 2'd3, 2'd0, 0);
    chk("mc.count", bus.stall_count, 3);
    // youngest wins, $0
    op("yw_w1",    1, 0, 5'd0, 0, 5'd0, 0, 1, 5'd7, 2'd0, 0, 0, 2'd0, 2'd0, 0);
    op("yw_w2",    1, 1, 5'd7, 0, 5'd0, 0, 1, 5'd7, 2'd0, 0, 0, 2'd1, 2'd0, 0);
    op("yw_rd",    1, 1, 5'd7, 1, 5'd7, 0, 0, 5'd0, 2'd0, 0, 0, 2'd1, 2'd1, 0);
    op("z_wr",     1, 0, 5'd0, 0, 5'd0, 0, 1, 5'd0, 2'd1, 0, 0, 2'd0, 2'd0, 0);
    op("z_rd",     1, 1, 5'd0, 1, 5'd0, 0, 0, 5'd0, 2'd0, 0, 0, 2'd0, 2'd0, 0);
    // store behind a 2-cycle writer stalls; flush overrides and inserts a bubble
    op("fl_wr",    1, 0, 5'd0, 0, 5'd0, 0, 1, 5'd10, 2'd2, 0, 0, 2'd0, 2'd0, 0);
    op("fl_sw",    1, 0, 5'd0, 1, 5'd10, 1, 0, 5'd0, 2'd0, 0, 1, 2'd0, 2'd0, 0);
    op("fl_flush", 1, 0, 5'd0, 1, 5'd10, 1, 1, 5'd11, 2'd0, 1, 0, 2'd0, 2'd0, 0);
    op("fl_after", 1, 1, 5'd11, 1, 5'd10, 0, 0, 5'd0, 2'd0, 0, 0, 2'd0, 2'd3, 0);
    chk("fl.count", bus.stall_count, 4);
    // unused operand
    op("un_wr",    1, 0, 5'd0, 0, 5'd0, 0, 1, 5'd12, 2'd1, 0, 0, 2'd0, 2'd0, 0);
    op("un_rd",    1, 0, 5'd12, 0, 5'd12, 0, 0, 5'd0, 2'd0, 0, 0, 2'd0, 2'd0, 0);
    // asynchronous reset during a stall
    op("rs_wr",    1, 0, 5'd0, 0, 5'd0, 0, 1, 5'd13, 2'd2, 0, 0, 2'd0, 2'd0, 0);
    op("rs_stall", 1, 1, 5'd13, 0, 5'd0, 0, 0, 5'd0, 2'd0, 0, 1, 2'd0, 2'd0, 0);
    chk("rs.count_pre", bus.stall_count, 4);
    #1 rst = 1'b1;
    #1;
    chk("rs.async_stall", 32'(bus.stall), 0);
    chk("rs.async_count", bus.stall_count, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    op("rs_after", 1, 1, 5'd13, 0, 5'd0, 0, 0, 5'd0, 2'd0, 0, 0, 2'd0, 2'd0, 0);
    chk("rs.count_post", bus.stall_count, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
